dnn_argmax_fp16: RTL and testbench
==================================

// Module: dnn_argmax_fp16
// PURPOSE
//  Classification stage downstream of the sigmoid inference engine. After the engine asserts
//  done, it scans the 10 output scores through the engine's out_idx/out read mux. It reports
//  the index of the largest signed score as the predicted digit, with a result-valid level.
// PARAMETERS
//  DATA_WIDTH   16   width of a signed fixed-point score
//  NUM_CLASSES  10   number of scores scanned, indices 0..NUM_CLASSES-1
//  IDX_WIDTH    4    width of out_idx and digit
//  CONF_THRESH  16'sd256  low-confidence margin threshold (used only with ARGMAX_CONF_EN)
// PORTS
//  clk        in   1           system clock, all state on rising edge
//  rst        in   1           asynchronous active-low reset
//  start      in   1           1-cycle pulse; connect to engine done (rising-edge qualified upstream)
//  clear      in   1           synchronous clear of result, returns to IDLE
//  out_idx    out  IDX_WIDTH   score select to engine read mux
//  out        in   DATA_WIDTH  signed score for out_idx, combinational from engine, same cycle
//  busy       out  1           scan in progress
//  valid      out  1           digit/max_val hold a completed result
//  digit      out  IDX_WIDTH   index of maximum score
//  max_val    out  DATA_WIDTH  maximum score value
//  margin     out  DATA_WIDTH  max minus runner-up (ARGMAX_CONF_EN only)
//  low_conf   out  1           margin < CONF_THRESH (ARGMAX_CONF_EN only)
// BEHAVIOUR
//  - Reset (rst=0, async): state IDLE; out_idx=0, busy=0, valid=0, digit=0, max_val=0,
//    margin=0, low_conf=0. Deassertion is synchronised by the top level, not by this block.
//  - FSM: IDLE -> SCAN on start; SCAN -> DONE after index NUM_CLASSES-1 is sampled;
//    DONE -> SCAN on start; any state -> IDLE on clear (clear wins over start).
//  - Timing: start sampled at edge E0 -> state SCAN, out_idx=0, busy=1. At each SCAN edge,
//    sample out for the current out_idx, then increment out_idx. The edge that samples
//    index 9 (E10) sets state DONE, busy=0, valid=1, and out_idx=0. Start-to-valid latency
//    is 10 cycles.
//  - Compare: signed, DATA_WIDTH bits. Index 0 unconditionally loads max. Index i replaces
//    max only if out > max (strict), so ties resolve to the lowest index.
//  - A running max/index pair is kept internally. digit/max_val update only at scan
//    completion and stay stable while busy.
//  - valid: a level held in DONE. It drops on the edge that accepts a new start or a clear.
//    Previous digit/max_val stay on the ports until the new result loads.
//  - Start while busy (SCAN): ignored; the scan is not restarted.
//  - Start in the same cycle as the final sample: ignored; the block enters DONE.
//  - out_idx never exceeds NUM_CLASSES-1. It is 0 outside SCAN.
//  - Reset mid-scan: all state is discarded immediately and nothing partial is exposed.
// CONFIGURATION
//  ARGMAX_CONF_EN defined:
//  - A runner-up register is also tracked. When a new max is found, the old max moves to
//    runner-up. Otherwise out > runner-up updates the runner-up. Runner-up is initialised
//    from index 1 ordering.
//  - At completion, margin = max - runner-up (non-negative, saturated to the signed max).
//  - low_conf = (margin < CONF_THRESH).
//  ARGMAX_CONF_EN undefined:
//  - No runner-up logic. margin and low_conf are tied to 0.
// TESTING
//  1. Scores {0..9}=100,200,...,1000; pulse start -> valid after exactly 10 cycles, digit=9,
//     max_val=1000, out_idx sequence 0..9 observed.
//  2. All scores -5 except idx3=-2 -> digit=3, max_val=-2 (signed compare check).
//  3. idx2=idx7=500, others 0 -> digit=2 (tie resolves to lowest index).
//  4. Start pulsed at scan cycle 4 -> ignored, valid still at cycle 10, same digit. Then
//     clear in DONE -> valid=0, out_idx=0, state IDLE.
//  5. rst=0 at scan cycle 5 -> all outputs 0 immediately. A new start after release gives
//     a correct full-latency result.
//  6. ARGMAX_CONF_EN: idx4=300, idx8=200, others 0 -> digit=4, margin=100, low_conf=1.
//     idx4=1000 with others 0 -> margin=1000, low_conf=0.

Source files
------------

// File: rtl/dnn_argmax_fp16.sv
// Argmax over NUM_CLASSES signed scores read through the engine's out_idx/out mux.
// Optional ARGMAX_CONF_EN adds runner-up tracking with margin and low_conf outputs.
module dnn_argmax_fp16 #(
  parameter int unsigned                  DATA_WIDTH  = 16,
  parameter int unsigned                  NUM_CLASSES = 10,
  parameter int unsigned                  IDX_WIDTH   = 4,
  parameter logic signed [DATA_WIDTH-1:0] CONF_THRESH = 16'sd256
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  clear,
  output logic [IDX_WIDTH-1:0]  out_idx,
  input  logic [DATA_WIDTH-1:0] out,
  output logic                  busy,
  output logic                  valid,
  output logic [IDX_WIDTH-1:0]  digit,
  output logic [DATA_WIDTH-1:0] max_val,
  output logic [DATA_WIDTH-1:0] margin,
  output logic                  low_conf
);

  localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(NUM_CLASSES - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e                        state_q, state_d;
  logic [IDX_WIDTH-1:0]          idx_q, idx_d;
  logic                          busy_q, busy_d;
  logic                          valid_q, valid_d;
  logic [IDX_WIDTH-1:0]          digit_q, digit_d;
  logic signed [DATA_WIDTH-1:0]  max_val_q, max_val_d;
  logic signed [DATA_WIDTH-1:0]  run_max_q, run_max_d;
  logic [IDX_WIDTH-1:0]          run_idx_q, run_idx_d;

  logic signed [DATA_WIDTH-1:0]  out_s;
  logic signed [DATA_WIDTH-1:0]  cand_max;
  logic [IDX_WIDTH-1:0]          cand_idx;

  assign out_s = $signed(out);

`ifdef ARGMAX_CONF_EN
  localparam logic signed [DATA_WIDTH-1:0] MIN_VAL = {1'b1, {(DATA_WIDTH-1){1'b0}}};
  localparam logic [DATA_WIDTH-1:0]        MAX_POS = {1'b0, {(DATA_WIDTH-1){1'b1}}};

  logic signed [DATA_WIDTH-1:0]  ru_q, ru_d;
  logic [DATA_WIDTH-1:0]         margin_q, margin_d;
  logic                          low_conf_q, low_conf_d;
  logic signed [DATA_WIDTH-1:0]  cand_ru;
  logic signed [DATA_WIDTH:0]    diff;
  logic [DATA_WIDTH-1:0]         margin_c;
`endif

  // Fold the current sample into the running max (strict > keeps the lowest index on ties).
  always_comb begin
    cand_max = run_max_q;
    cand_idx = run_idx_q;
`ifdef ARGMAX_CONF_EN
    cand_ru  = ru_q;
`endif
    if (idx_q == '0) begin
      cand_max = out_s;
      cand_idx = idx_q;
`ifdef ARGMAX_CONF_EN
      cand_ru  = MIN_VAL;
`endif
    end else if (out_s > run_max_q) begin
      cand_max = out_s;
      cand_idx = idx_q;
`ifdef ARGMAX_CONF_EN
      cand_ru  = run_max_q;
`endif
    end
`ifdef ARGMAX_CONF_EN
    else if (out_s > ru_q) begin
      cand_ru = out_s;
    end
`endif
  end

`ifdef ARGMAX_CONF_EN
  // Difference is non-negative; saturate anything beyond the signed positive range.
  always_comb begin
    diff     = (DATA_WIDTH+1)'(cand_max) - (DATA_WIDTH+1)'(cand_ru);
    margin_c = diff[DATA_WIDTH-1] ? MAX_POS : diff[DATA_WIDTH-1:0];
  end
`endif

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    busy_d    = busy_q;
    valid_d   = valid_q;
    digit_d   = digit_q;
    max_val_d = max_val_q;
    run_max_d = run_max_q;
    run_idx_d = run_idx_q;
`ifdef ARGMAX_CONF_EN
    ru_d       = ru_q;
    margin_d   = margin_q;
    low_conf_d = low_conf_q;
`endif

    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d = ST_SCAN;
          idx_d   = '0;
          busy_d  = 1'b1;
          valid_d = 1'b0;
        end
      end
      ST_SCAN: begin
        run_max_d = cand_max;
        run_idx_d = cand_idx;
`ifdef ARGMAX_CONF_EN
        ru_d      = cand_ru;
`endif
        if (idx_q == LAST_IDX) begin
          state_d   = ST_DONE;
          idx_d     = '0;
          busy_d    = 1'b0;
          valid_d   = 1'b1;
          digit_d   = cand_idx;
          max_val_d = cand_max;
`ifdef ARGMAX_CONF_EN
          margin_d   = margin_c;
          low_conf_d = $signed(margin_c) < CONF_THRESH;
`endif
        end else begin
          idx_d = idx_q + IDX_WIDTH'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        idx_d   = '0;
        busy_d  = 1'b0;
        valid_d = 1'b0;
      end
    endcase

    if (clear) begin
      state_d   = ST_IDLE;
      idx_d     = '0;
      busy_d    = 1'b0;
      valid_d   = 1'b0;
      digit_d   = '0;
      max_val_d = '0;
`ifdef ARGMAX_CONF_EN
      margin_d   = '0;
      low_conf_d = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      busy_q    <= 1'b0;
      valid_q   <= 1'b0;
      digit_q   <= '0;
      max_val_q <= '0;
      run_max_q <= '0;
      run_idx_q <= '0;
`ifdef ARGMAX_CONF_EN
      ru_q       <= '0;
      margin_q   <= '0;
      low_conf_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      busy_q    <= busy_d;
      valid_q   <= valid_d;
      digit_q   <= digit_d;
      max_val_q <= max_val_d;
      run_max_q <= run_max_d;
      run_idx_q <= run_idx_d;
`ifdef ARGMAX_CONF_EN
      ru_q       <= ru_d;
      margin_q   <= margin_d;
      low_conf_q <= low_conf_d;
`endif
    end
  end

  assign out_idx = idx_q;
  assign busy    = busy_q;
  assign valid   = valid_q;
  assign digit   = digit_q;
  assign max_val = max_val_q;

`ifdef ARGMAX_CONF_EN
  assign margin   = margin_q;
  assign low_conf = low_conf_q;
`else
  logic unused_conf;
  assign unused_conf = ^CONF_THRESH;
  assign margin      = '0;
  assign low_conf    = 1'b0;
`endif

endmodule

// File: tb/tb_dnn_argmax_fp16.sv
// Directed bench for dnn_argmax_fp16: vector table plus hand-written start/clear/reset sequences.
module tb_dnn_argmax_fp16;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        clear;
  logic [3:0]  out_idx;
  logic [15:0] out;
  logic        busy;
  logic        valid;
  logic [3:0]  digit;
  logic [15:0] max_val;
  logic [15:0] margin;
  logic        low_conf;

  logic [9:0][15:0] sc_cur;

  int pass_cnt = 0;
  int total    = 0;

  always #5 clk = ~clk;

  dnn_argmax_fp16 dut (
    .clk(clk), .rst(rst), .start(start), .clear(clear),
    .out_idx(out_idx), .out(out), .busy(busy), .valid(valid),
    .digit(digit), .max_val(max_val), .margin(margin), .low_conf(low_conf)
  );

  // Engine read mux model.
  always_comb out = (out_idx < 4'd10) ? sc_cur[out_idx] : 16'h0000;

  typedef struct {
    logic [9:0][15:0] sc;
    logic [3:0]       exp_digit;
    logic [15:0]      exp_max;
    logic [15:0]      exp_margin;
    logic             exp_low;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp)
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else
      pass_cnt++;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Pulse start, optionally re-pulse start just before edge pulse_at, return edges to valid.
  task automatic run_scan(input string tag, input int pulse_at, output int lat);
    logic idx_ok;
    idx_ok = 1'b1;
    lat    = -1;
    start  = 1'b1;
    step();
    start  = 1'b0;
    check({tag, "_busy_after_start"}, 32'(busy), 32'd1);
    check({tag, "_valid_drop_on_start"}, 32'(valid), 32'd0);
    for (int c = 1; c <= 20; c++) begin
      if (out_idx !== 4'(c - 1)) idx_ok = 1'b0;
      start = (c == pulse_at);
      step();
      start = 1'b0;
      if (valid === 1'b1) begin
        lat = c;
        break;
      end
    end
    check({tag, "_idx_seq"}, 32'(idx_ok), 32'd1);
    check({tag, "_latency"}, 32'(lat), 32'd10);
    check({tag, "_busy_done"}, 32'(busy), 32'd0);
    check({tag, "_idx_done"}, 32'(out_idx), 32'd0);
  endtask

  task automatic check_result(input string tag, input int v);
    check({tag, "_digit"}, 32'(digit), 32'(vecs[v].exp_digit));
    check({tag, "_max"}, 32'(max_val), 32'(vecs[v].exp_max));
`ifdef ARGMAX_CONF_EN
    check({tag, "_margin"}, 32'(margin), 32'(vecs[v].exp_margin));
    check({tag, "_low"}, 32'(low_conf), 32'(vecs[v].exp_low));
`else
    check({tag, "_margin"}, 32'(margin), 32'd0);
    check({tag, "_low"}, 32'(low_conf), 32'd0);
`endif
  endtask

  initial begin
    int lat;
    for (int v = 0; v < 7; v++) begin
      for (int i = 0; i < 10; i++) vecs[v].sc[i] = 16'h0000;
    end
    // Ascending 100..1000.
    for (int i = 0; i < 10; i++) vecs[0].sc[i] = 16'(100 * (i + 1));
    vecs[0].exp_digit = 4'd9; vecs[0].exp_max = 16'd1000; vecs[0].exp_margin = 16'd100; vecs[0].exp_low = 1'b1;
    // All -5 except idx3 = -2.
    for (int i = 0; i < 10; i++) vecs[1].sc[i] = 16'hFFFB;
    vecs[1].sc[3] = 16'hFFFE;
    vecs[1].exp_digit = 4'd3; vecs[1].exp_max = 16'hFFFE; vecs[1].exp_margin = 16'd3; vecs[1].exp_low = 1'b1;
    // Tie idx2 = idx7 = 500.
    vecs[2].sc[2] = 16'd500; vecs[2].sc[7] = 16'd500;
    vecs[2].exp_digit = 4'd2; vecs[2].exp_max = 16'd500; vecs[2].exp_margin = 16'd0; vecs[2].exp_low = 1'b1;
    // idx4 = 300, idx8 = 200.
    vecs[3].sc[4] = 16'd300; vecs[3].sc[8] = 16'd200;
    vecs[3].exp_digit = 4'd4; vecs[3].exp_max = 16'd300; vecs[3].exp_margin = 16'd100; vecs[3].exp_low = 1'b1;
    // idx4 = 1000.
    vecs[4].sc[4] = 16'd1000;
    vecs[4].exp_digit = 4'd4; vecs[4].exp_max = 16'd1000; vecs[4].exp_margin = 16'd1000; vecs[4].exp_low = 1'b0;
    // Extremes: margin saturates at 32767.
    for (int i = 0; i < 10; i++) vecs[5].sc[i] = 16'h8000;
    vecs[5].sc[0] = 16'h7FFF;
    vecs[5].exp_digit = 4'd0; vecs[5].exp_max = 16'h7FFF; vecs[5].exp_margin = 16'h7FFF; vecs[5].exp_low = 1'b0;
    // All most-negative: idx0 wins, zero margin.
    for (int i = 0; i < 10; i++) vecs[6].sc[i] = 16'h8000;
    vecs[6].exp_digit = 4'd0; vecs[6].exp_max = 16'h8000; vecs[6].exp_margin = 16'd0; vecs[6].exp_low = 1'b1;

    rst = 1'b0; start = 1'b0; clear = 1'b0; sc_cur = vecs[0].sc;
    step(); step();
    check("rst_idx", 32'(out_idx), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_digit", 32'(digit), 32'd0);
    check("rst_max", 32'(max_val), 32'd0);
    check("rst_margin", 32'(margin), 32'd0);
    check("rst_low", 32'(low_conf), 32'd0);
    @(negedge clk); rst = 1'b1;
    step();

    for (int v = 0; v < 7; v++) begin
      sc_cur = vecs[v].sc;
      run_scan($sformatf("vec%0d", v), -1, lat);
      check_result($sformatf("vec%0d", v), v);
      step();
      check($sformatf("vec%0d_valid_hold", v), 32'(valid), 32'd1);
    end

    // New start drops valid but keeps the previous result on the ports.
    sc_cur = vecs[1].sc;
    start = 1'b1; step(); start = 1'b0;
    check("restart_valid", 32'(valid), 32'd0);
    check("restart_digit_kept", 32'(digit), 32'(vecs[6].exp_digit));
    check("restart_max_kept", 32'(max_val), 32'(vecs[6].exp_max));
    for (int c = 0; c < 4; c++) step();
    check("midscan_digit_stable", 32'(digit), 32'(vecs[6].exp_digit));
    clear = 1'b1; step(); clear = 1'b0;
    check("clear_scan_busy", 32'(busy), 32'd0);
    check("clear_scan_idx", 32'(out_idx), 32'd0);

    // Start during scan cycle 4 is ignored.
    sc_cur = vecs[0].sc;
    run_scan("midstart", 4, lat);
    check_result("midstart", 0);
    clear = 1'b1; step(); clear = 1'b0;
    check("clear_valid", 32'(valid), 32'd0);
    check("clear_idx", 32'(out_idx), 32'd0);
    check("clear_busy", 32'(busy), 32'd0);
    step();
    check("idle_stays", 32'(busy), 32'd0);

    // Clear wins over start.
    start = 1'b1; clear = 1'b1; step(); start = 1'b0; clear = 1'b0;
    check("clear_beats_start", 32'(busy), 32'd0);

    // Start coincident with the final sample is ignored.
    sc_cur = vecs[3].sc;
    run_scan("finalstart", 10, lat);
    check_result("finalstart", 3);
    step();
    check("finalstart_still_done", 32'(valid), 32'd1);
    check("finalstart_no_scan", 32'(busy), 32'd0);

    // Async reset mid-scan.
    sc_cur = vecs[2].sc;
    start = 1'b1; step(); start = 1'b0;
    for (int c = 0; c < 5; c++) step();
    #2 rst = 1'b0;
    #1;
    check("midrst_idx", 32'(out_idx), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_valid", 32'(valid), 32'd0);
    check("midrst_digit", 32'(digit), 32'd0);
    check("midrst_max", 32'(max_val), 32'd0);
    check("midrst_margin", 32'(margin), 32'd0);
    check("midrst_low", 32'(low_conf), 32'd0);
    step();
    @(negedge clk); rst = 1'b1;
    step();
    check("postrst_idle", 32'(busy), 32'd0);
    sc_cur = vecs[4].sc;
    run_scan("postrst", -1, lat);
    check_result("postrst", 4);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
